mem_ctrl: RTL and testbench

- Memory-side responder for the byte-serial RAM port. It serves the fetch stage's byte-per-cycle instruction reads and the MEM stage's 1/2/4-byte loads and stores.
- Arbitrates between the two requesters with MEM priority.
- Drives the single 8-bit RAM port and reports data ownership back to the requesters (01 = IF, 10 = MEM).
- Raises a stall request to ctrl while a MEM transaction owns the port.

---
 rtl/mem_ctrl_if.sv | 23 ++
 rtl/mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// MEM-stage request bus into the RAM port controller.
// The MEM stage is the master; mem_ctrl is the slave.
interface mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  modport master (
    output mem_req, mem_we, mem_width,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_req, mem_we, mem_width,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port: serves IF byte fetches and
// MEM 1/2/4-byte loads/stores, MEM taking priority.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_request,
  input  logic [31:0]       if_addr,
  output logic [7:0]        mem_ctrl_data,
  output logic [1:0]        if_or_mem_o,
  mem_ctrl_if.slave         mbus,
  output logic              mem_stall_req,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {
    IDLE, LOAD, STORE, DONE
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic [1:0]        acc_last;
  logic [31:0]       base;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       keep;
  logic [31:0]       st_addr;
  logic [31:0]       ld_addr;
  logic [ADDR_W-1:0] ram_a_q;
  logic              done;
  logic [1:0]        owner;

  assign mem_ctrl_data  = ram_din;
  assign if_or_mem_o    = owner;
  assign mbus.mem_rdata = rdata;
  assign mbus.mem_done  = done;
  assign mem_stall_req  = mbus.mem_req
                        | (state != IDLE);

  // Byte i sits at base+i with 32-bit wrap;
  // a load addresses one byte ahead of capture.
  assign st_addr = base + 32'(cnt);
  assign ld_addr = base + 32'(cnt) + 32'd1;

  // Last byte index and bytes kept on load accept.
  always_comb begin
    acc_last = 2'd3;
    keep     = 32'hffff_ffff;
    unique case (1'b1)
      (mbus.mem_width == 2'b00): begin
        acc_last = 2'd0;
        keep     = 32'h0000_00ff;
      end
      (mbus.mem_width == 2'b01): begin
        acc_last = 2'd1;
        keep     = 32'h0000_ffff;
      end
      default: ;
    endcase
  end

  // RAM port drive; ram_wr is gated by reset.
  always_comb begin
    ram_a    = ram_a_q;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    case (state)
      IDLE: begin
        if (mbus.mem_req) begin
          ram_a    = mbus.mem_addr[ADDR_W-1:0];
          ram_wr   = mbus.mem_we;
          ram_dout = mbus.mem_wdata[7:0];
        end else if (if_request) begin
          ram_a = if_addr[ADDR_W-1:0];
        end
      end
      LOAD: begin
        if (cnt != last)
          ram_a = ld_addr[ADDR_W-1:0];
      end
      STORE: begin
        ram_a    = st_addr[ADDR_W-1:0];
        ram_wr   = 1'b1;
        ram_dout = wdata[{cnt, 3'b000} +: 8];
      end
      default: ;
    endcase
    if (rst)
      ram_wr = 1'b0;
  end

  // Transaction FSM with registered owner/done/rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      last    <= 2'd0;
      base    <= 32'd0;
      wdata   <= 32'd0;
      rdata   <= 32'd0;
      done    <= 1'b0;
      owner   <= 2'b00;
      ram_a_q <= '0;
    end else begin
      ram_a_q <= ram_a;
      done    <= 1'b0;
      owner   <= 2'b00;
      case (state)
        IDLE: begin
          if (mbus.mem_req) begin
            base  <= mbus.mem_addr;
            wdata <= mbus.mem_wdata;
            last  <= acc_last;
            if (mbus.mem_we) begin
              cnt <= 2'd1;
              if (acc_last == 2'd0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= STORE;
              end
            end else begin
              cnt   <= 2'd0;
              state <= LOAD;
              owner <= 2'b10;
              rdata <= rdata & keep;
            end
          end else if (if_request) begin
            owner <= 2'b01;
          end
        end
        LOAD: begin
          rdata[{cnt, 3'b000} +: 8] <= ram_din;
          if (cnt == last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 2'd1;
            owner <= 2'b10;
          end
        end
        STORE: begin
          if (cnt == last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model
// and queues of expected IF bytes / MEM completions.
module tb_mem_ctrl;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_request = 1'b0;
  logic [31:0]   if_addr = 32'd0;
  logic [7:0]    mem_ctrl_data;
  logic [1:0]    if_or_mem_o;
  logic          mem_stall_req;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic [AW-1:0] ram_a;
  logic          ram_wr;

  mem_ctrl_if mbus ();

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_request    (if_request),
    .if_addr       (if_addr),
    .mem_ctrl_data (mem_ctrl_data),
    .if_or_mem_o   (if_or_mem_o),
    .mbus          (mbus),
    .mem_stall_req (mem_stall_req),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_a         (ram_a),
    .ram_wr        (ram_wr)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:(1<<AW)-1];

  // RAM model: registered read, write on ram_wr.
  always @(posedge clk) begin
    if (rst) begin
      ram[0]     <= 8'h13;
      ram[1]     <= 8'h00;
      ram[2]     <= 8'h00;
      ram[3]     <= 8'h00;
      ram[17'h100] <= 8'h78;
      ram[17'h101] <= 8'h56;
      ram[17'h102] <= 8'h34;
      ram[17'h103] <= 8'h12;
      ram[17'h200] <= 8'h11;
      ram[17'h201] <= 8'h22;
      ram[17'h202] <= 8'h33;
      ram[17'h203] <= 8'h44;
    end else if (ram_wr) begin
      ram[ram_a] <= ram_dout;
    end
    ram_din <= ram[ram_a];
  end

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } done_t;

  logic [7:0] if_q[$];
  done_t      done_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_done(input bit ld,
                           input logic [31:0] d);
    done_t e;
    e.is_load = ld;
    e.data    = d;
    done_q.push_back(e);
  endtask

  // Scoreboard: pop on each IF delivery / mem_done.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_or_mem_o == 2'b01) begin
        if (if_q.size() == 0)
          chk("if_q_empty", 32'(if_q.size()), 32'd1);
        else
          chk("if_data", 32'(mem_ctrl_data),
              32'(if_q.pop_front()));
      end
      if (mbus.mem_done) begin
        if (done_q.size() == 0) begin
          chk("done_q_empty", 32'(done_q.size()), 32'd1);
        end else begin
          done_t d;
          d = done_q.pop_front();
          if (d.is_load)
            chk("load_rdata", mbus.mem_rdata, d.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mbus.mem_req   = 1'b0;
    mbus.mem_we    = 1'b0;
    mbus.mem_width = 2'b00;
    mbus.mem_addr  = 32'd0;
    mbus.mem_wdata = 32'd0;

    // reset state
    tick();
    tick();
    settle();
    chk("rst_rdata", mbus.mem_rdata, 32'd0);
    chk("rst_done", 32'(mbus.mem_done), 32'd0);
    chk("rst_owner", 32'(if_or_mem_o), 32'd0);
    chk("rst_wr", 32'(ram_wr), 32'd0);
    chk("rst_stall", 32'(mem_stall_req), 32'd0);

    // IF stream 0..3
    for (int i = 0; i < 4; i++) begin
      tick();
      rst        = 1'b0;
      if_request = 1'b1;
      if_addr    = 32'(i);
      settle();
      chk("if_ram_a", 32'(ram_a), 32'(i));
      chk("if_wr", 32'(ram_wr), 32'd0);
      if_q.push_back(i == 0 ? 8'h13 : 8'h00);
    end
    tick();
    if_request = 1'b0;
    settle();
    chk("if_owner_last", 32'(if_or_mem_o), 32'd1);
    chk("if_stall", 32'(mem_stall_req), 32'd0);

    // word load at 0x100
    tick();
    mbus.mem_req   = 1'b1;
    mbus.mem_we    = 1'b0;
    mbus.mem_width = 2'b10;
    mbus.mem_addr  = 32'h100;
    settle();
    push_done(1'b1, 32'h1234_5678);
    chk("wl_a0", 32'(ram_a), 32'h100);
    chk("wl_wr0", 32'(ram_wr), 32'd0);
    chk("wl_stall0", 32'(mem_stall_req), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      settle();
      chk("wl_a", 32'(ram_a), 32'h100 + 32'(i));
      chk("wl_owner", 32'(if_or_mem_o), 32'd2);
    end
    tick();
    settle();
    chk("wl_owner4", 32'(if_or_mem_o), 32'd2);
    chk("wl_done4", 32'(mbus.mem_done), 32'd0);
    tick();
    settle();
    chk("wl_done5", 32'(mbus.mem_done), 32'd1);
    chk("wl_stall5", 32'(mem_stall_req), 32'd1);
    tick();
    mbus.mem_req = 1'b0;
    settle();
    chk("wl_done6", 32'(mbus.mem_done), 32'd0);
    chk("wl_stall6", 32'(mem_stall_req), 32'd0);

    // half store at 0x201
    tick();
    mbus.mem_req   = 1'b1;
    mbus.mem_we    = 1'b1;
    mbus.mem_width = 2'b01;
    mbus.mem_addr  = 32'h201;
    mbus.mem_wdata = 32'haabb_ccdd;
    settle();
    push_done(1'b0, 32'd0);
    chk("hs_wr0", 32'(ram_wr), 32'd1);
    chk("hs_a0", 32'(ram_a), 32'h201);
    chk("hs_d0", 32'(ram_dout), 32'hdd);
    tick();
    settle();
    chk("hs_wr1", 32'(ram_wr), 32'd1);
    chk("hs_a1", 32'(ram_a), 32'h202);
    chk("hs_d1", 32'(ram_dout), 32'hcc);
    chk("hs_done1", 32'(mbus.mem_done), 32'd0);
    tick();
    settle();
    chk("hs_done2", 32'(mbus.mem_done), 32'd1);
    chk("hs_wr2", 32'(ram_wr), 32'd0);
    tick();
    mbus.mem_req = 1'b0;
    settle();
    chk("hs_ram", {ram[17'h203], ram[17'h202],
                   ram[17'h201], ram[17'h200]},
        32'h44cc_dd11);

    // byte load at 0x203
    tick();
    mbus.mem_req   = 1'b1;
    mbus.mem_we    = 1'b0;
    mbus.mem_width = 2'b00;
    mbus.mem_addr  = 32'h203;
    settle();
    push_done(1'b1, 32'h0000_0044);
    tick();
    settle();
    chk("bl_owner1", 32'(if_or_mem_o), 32'd2);
    chk("bl_done1", 32'(mbus.mem_done), 32'd0);
    tick();
    settle();
    chk("bl_done2", 32'(mbus.mem_done), 32'd1);
    tick();
    mbus.mem_req = 1'b0;
    settle();

    // contention: MEM wins, IF after DONE
    tick();
    mbus.mem_req   = 1'b1;
    mbus.mem_we    = 1'b0;
    mbus.mem_width = 2'b00;
    mbus.mem_addr  = 32'h100;
    if_request     = 1'b1;
    if_addr        = 32'd0;
    settle();
    push_done(1'b1, 32'h0000_0078);
    chk("ct_a0", 32'(ram_a), 32'h100);
    chk("ct_stall0", 32'(mem_stall_req), 32'd1);
    tick();
    settle();
    chk("ct_owner1", 32'(if_or_mem_o), 32'd2);
    chk("ct_stall1", 32'(mem_stall_req), 32'd1);
    tick();
    settle();
    chk("ct_done2", 32'(mbus.mem_done), 32'd1);
    chk("ct_stall2", 32'(mem_stall_req), 32'd1);
    chk("ct_owner2", 32'(if_or_mem_o), 32'd0);
    tick();
    mbus.mem_req = 1'b0;
    settle();
    chk("ct_if_a", 32'(ram_a), 32'd0);
    chk("ct_stall3", 32'(mem_stall_req), 32'd0);
    if_q.push_back(8'h13);
    tick();
    if_request = 1'b0;
    settle();
    chk("ct_owner4", 32'(if_or_mem_o), 32'd1);

    // reset in cycle 1 of a word store
    tick();
    mbus.mem_req   = 1'b1;
    mbus.mem_we    = 1'b1;
    mbus.mem_width = 2'b10;
    mbus.mem_addr  = 32'h300;
    mbus.mem_wdata = 32'h0102_0304;
    settle();
    chk("rs_wr0", 32'(ram_wr), 32'd1);
    tick();
    rst = 1'b1;
    settle();
    chk("rs_wr1", 32'(ram_wr), 32'd0);
    tick();
    rst          = 1'b0;
    mbus.mem_req = 1'b0;
    settle();
    chk("rs_stall", 32'(mem_stall_req), 32'd0);
    chk("rs_done", 32'(mbus.mem_done), 32'd0);
    chk("rs_owner", 32'(if_or_mem_o), 32'd0);
    chk("rs_rdata", mbus.mem_rdata, 32'd0);
    chk("rs_wr2", 32'(ram_wr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("rs_no_done", 32'(mbus.mem_done), 32'd0);
    end

    chk("if_q_left", 32'(if_q.size()), 32'd0);
    chk("done_q_left", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
